// File: rtl/countdown_timer_bcd_pkg.sv
// Shared definitions for the BCD mm:ss countdown timer: FSM encoding, digit limits and
// the preset clamp helper.
package countdown_timer_bcd_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] SEC10_MAX = 4'd5;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
    return (d > max) ? max : d;
  endfunction

endpackage

// File: rtl/countdown_timer_bcd_counter_dec_down.sv
// Two-digit BCD down counter with synchronous clear/load, decrement enable,
// combinational borrow-out (decrement while at 00) and zero flag.
module counter_dec_down
  import countdown_timer_bcd_pkg::*;
#(
  parameter logic [3:0] TENS_MAX = 4'd9
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] ld_tens,
  input  logic [3:0] ld_ones,
  input  logic       dec,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       borrow,
  output logic       zero
);

  assign zero   = (tens == 4'd0) && (ones == 4'd0);
  assign borrow = dec && zero;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (clr) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (load) begin
      tens <= ld_tens;
      ones <= ld_ones;
    end else if (dec) begin
      if (ones == 4'd0) begin
        ones <= DIGIT_MAX;
        tens <= (tens == 4'd0) ? TENS_MAX : tens - 4'd1;
      end else begin
        ones <= ones - 4'd1;
      end
    end
  end

endmodule

// File: rtl/countdown_timer_bcd.sv
// BCD mm:ss countdown timer: strobe-priority FSM, preset clamping and timeout alarm
// around two cascaded two-digit down counters.
module countdown_timer_bcd
  import countdown_timer_bcd_pkg::*;
#(
  parameter int unsigned ALARM_SEC = 10
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       clk_sec,
  input  logic       load,
  input  logic [3:0] ld_min10,
  input  logic [3:0] ld_min1,
  input  logic [3:0] ld_sec10,
  input  logic [3:0] ld_sec1,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] min10,
  output logic [3:0] min1,
  output logic [3:0] sec10,
  output logic [3:0] sec1,
  output logic       running,
  output logic       timeout,
  output logic       timeout_pulse
);

  localparam int unsigned AW = (ALARM_SEC > 0) ? $clog2(ALARM_SEC + 1) : 1;
  localparam logic [AW-1:0] ALARM_LIMIT = AW'(ALARM_SEC);

  state_e state_q, state_d;
  logic [AW-1:0] alarm_q;
  logic cnt_clr, cnt_load, sec_dec, alarm_inc;
  logic sec_borrow, sec_zero, min_zero;
  logic is_zero, is_one;

  assign is_zero = sec_zero && min_zero;
  assign is_one  = min_zero && (sec10 == 4'd0) && (sec1 == 4'd1);

  always_comb begin
    state_d   = state_q;
    cnt_clr   = 1'b0;
    cnt_load  = 1'b0;
    sec_dec   = 1'b0;
    alarm_inc = 1'b0;
    // Only the highest-priority strobe of a cycle acts.
    if (clear) begin
      cnt_clr = 1'b1;
      state_d = StIdle;
    end else if (load) begin
      if (state_q != StRun) begin
        cnt_load = 1'b1;
        state_d  = StIdle;
      end
    end else if (start_stop) begin
      unique case (state_q)
        StIdle:  if (!is_zero) state_d = StRun;
        StRun:   state_d = StPause;
        StPause: state_d = StRun;
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end else if (clk_sec) begin
      if (state_q == StRun) begin
        sec_dec = 1'b1;
        if (is_one) state_d = StDone;
      end else if (state_q == StDone && ALARM_SEC != 0) begin
        alarm_inc = 1'b1;
        if (alarm_q + 1'b1 == ALARM_LIMIT) state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q       <= StIdle;
      alarm_q       <= '0;
      running       <= 1'b0;
      timeout       <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state_q       <= state_d;
      running       <= (state_d == StRun);
      timeout       <= (state_d == StDone);
      timeout_pulse <= (state_d == StDone) && (state_q != StDone);
      if (state_d == StDone && state_q != StDone) begin
        alarm_q <= '0;
      end else if (alarm_inc) begin
        alarm_q <= alarm_q + 1'b1;
      end
    end
  end

  counter_dec_down #(
    .TENS_MAX (SEC10_MAX)
  ) u_sec (
    .clk     (clk),
    .reset_p (reset_p),
    .clr     (cnt_clr),
    .load    (cnt_load),
    .ld_tens (clamp_digit(ld_sec10, SEC10_MAX)),
    .ld_ones (clamp_digit(ld_sec1, DIGIT_MAX)),
    .dec     (sec_dec),
    .tens    (sec10),
    .ones    (sec1),
    .borrow  (sec_borrow),
    .zero    (sec_zero)
  );

  // Minutes never borrow: the RUN->DONE transition stops the count at 00:00.
  counter_dec_down #(
    .TENS_MAX (DIGIT_MAX)
  ) u_min (
    .clk     (clk),
    .reset_p (reset_p),
    .clr     (cnt_clr),
    .load    (cnt_load),
    .ld_tens (clamp_digit(ld_min10, DIGIT_MAX)),
    .ld_ones (clamp_digit(ld_min1, DIGIT_MAX)),
    .dec     (sec_borrow),
    .tens    (min10),
    .ones    (min1),
    .borrow  (),
    .zero    (min_zero)
  );

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Scoreboard bench for countdown_timer_bcd: three instances (ALARM_SEC 10, 3, 0) share
// directed stimulus; expected outputs are queued and checked at the falling edge.
module tb_countdown_timer_bcd;

  logic clk = 1'b0;
  logic reset_p = 1'b1;
  logic clk_sec = 1'b0, load = 1'b0, start_stop = 1'b0, clear = 1'b0;
  logic [3:0] ld_min10 = '0, ld_min1 = '0, ld_sec10 = '0, ld_sec1 = '0;

  logic [3:0] m10 [3], m1 [3], s10 [3], s1 [3];
  logic       run [3], to [3], tp [3];

  typedef struct {
    string       name;
    int          which;
    logic [15:0] digits;
    logic        run;
    logic        to;
    logic        tp;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  countdown_timer_bcd #(.ALARM_SEC(10)) dut (
    .clk(clk), .reset_p(reset_p), .clk_sec(clk_sec), .load(load),
    .ld_min10(ld_min10), .ld_min1(ld_min1), .ld_sec10(ld_sec10), .ld_sec1(ld_sec1),
    .start_stop(start_stop), .clear(clear),
    .min10(m10[0]), .min1(m1[0]), .sec10(s10[0]), .sec1(s1[0]),
    .running(run[0]), .timeout(to[0]), .timeout_pulse(tp[0])
  );

  countdown_timer_bcd #(.ALARM_SEC(3)) dut_a3 (
    .clk(clk), .reset_p(reset_p), .clk_sec(clk_sec), .load(load),
    .ld_min10(ld_min10), .ld_min1(ld_min1), .ld_sec10(ld_sec10), .ld_sec1(ld_sec1),
    .start_stop(start_stop), .clear(clear),
    .min10(m10[1]), .min1(m1[1]), .sec10(s10[1]), .sec1(s1[1]),
    .running(run[1]), .timeout(to[1]), .timeout_pulse(tp[1])
  );

  countdown_timer_bcd #(.ALARM_SEC(0)) dut_a0 (
    .clk(clk), .reset_p(reset_p), .clk_sec(clk_sec), .load(load),
    .ld_min10(ld_min10), .ld_min1(ld_min1), .ld_sec10(ld_sec10), .ld_sec1(ld_sec1),
    .start_stop(start_stop), .clear(clear),
    .min10(m10[2]), .min1(m1[2]), .sec10(s10[2]), .sec1(s1[2]),
    .running(run[2]), .timeout(to[2]), .timeout_pulse(tp[2])
  );

  // Monitor: outputs are stable at the falling edge; drain every pending expectation.
  initial begin
    exp_t r;
    logic [18:0] act, want;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        act  = {m10[r.which], m1[r.which], s10[r.which], s1[r.which],
                run[r.which], to[r.which], tp[r.which]};
        want = {r.digits, r.run, r.to, r.tp};
        total++;
        if (act !== want) begin
          bad++;
          $display("FAIL %s (inst %0d): got %h run=%b to=%b tp=%b, want %h run=%b to=%b tp=%b",
                   r.name, r.which, act[18:3], act[2], act[1], act[0],
                   r.digits, r.run, r.to, r.tp);
        end
      end
    end
  end

  task automatic expect_out(input string name, input int which, input logic [15:0] digits,
                            input logic r, input logic t, input logic p);
    exp_t e;
    e.name = name; e.which = which; e.digits = digits; e.run = r; e.to = t; e.tp = p;
    exp_q.push_back(e);
  endtask

  // Hold the given strobes for exactly one rising edge.
  task automatic cyc(input logic l, input logic ss, input logic cs, input logic cl,
                     input logic [15:0] d);
    @(posedge clk); #1;
    load = l; start_stop = ss; clk_sec = cs; clear = cl;
    ld_min10 = d[15:12]; ld_min1 = d[11:8]; ld_sec10 = d[7:4]; ld_sec1 = d[3:0];
    @(posedge clk); #1;
    load = 1'b0; start_stop = 1'b0; clk_sec = 1'b0; clear = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    expect_out("reset_state", 0, 16'h0000, 0, 0, 0);
    reset_p = 1'b0;

    // 01:00 down to zero
    cyc(1, 0, 0, 0, 16'h0100);
    expect_out("load_0100", 0, 16'h0100, 0, 0, 0);
    cyc(0, 1, 0, 0, 16'h0);
    expect_out("start_run", 0, 16'h0100, 1, 0, 0);
    tick(1);
    expect_out("first_tick", 0, 16'h0059, 1, 0, 0);
    tick(58);
    expect_out("at_0001", 0, 16'h0001, 1, 0, 0);
    tick(1);
    expect_out("reach_zero", 0, 16'h0000, 0, 1, 1);
    expect_out("reach_zero_a3", 1, 16'h0000, 0, 1, 1);
    expect_out("reach_zero_a0", 2, 16'h0000, 0, 1, 1);
    cyc(0, 0, 0, 0, 16'h0);
    expect_out("pulse_one_cycle", 0, 16'h0000, 0, 1, 0);

    // Alarm hold lengths: 3, 10 and forever
    tick(2);
    expect_out("a3_after_2", 1, 16'h0000, 0, 1, 0);
    tick(1);
    expect_out("a3_after_3", 1, 16'h0000, 0, 0, 0);
    tick(6);
    expect_out("a10_after_9", 0, 16'h0000, 0, 1, 0);
    tick(1);
    expect_out("a10_after_10", 0, 16'h0000, 0, 0, 0);
    tick(10);
    expect_out("a0_after_20", 2, 16'h0000, 0, 1, 0);
    cyc(0, 0, 0, 1, 16'h0);
    expect_out("a0_clear", 2, 16'h0000, 0, 0, 0);

    // Double borrow 10:00 -> 09:59
    cyc(1, 0, 0, 0, 16'h1000);
    cyc(0, 1, 0, 0, 16'h0);
    tick(1);
    expect_out("double_borrow", 0, 16'h0959, 1, 0, 0);
    cyc(0, 0, 0, 1, 16'h0);
    expect_out("clear_in_run", 0, 16'h0000, 0, 0, 0);

    // Pause behaviour from 00:05
    cyc(1, 0, 0, 0, 16'h0005);
    cyc(0, 1, 0, 0, 16'h0);
    tick(2);
    expect_out("run_0003", 0, 16'h0003, 1, 0, 0);
    cyc(0, 1, 1, 0, 16'h0);
    expect_out("pause_wins_tick", 0, 16'h0003, 0, 0, 0);
    tick(3);
    expect_out("paused_frozen", 0, 16'h0003, 0, 0, 0);
    cyc(0, 1, 0, 0, 16'h0);
    expect_out("resume", 0, 16'h0003, 1, 0, 0);
    tick(2);
    expect_out("resume_0001", 0, 16'h0001, 1, 0, 0);
    tick(1);
    expect_out("resume_done", 0, 16'h0000, 0, 1, 1);
    cyc(0, 0, 0, 1, 16'h0);

    // Clamping and start at zero
    cyc(1, 0, 0, 0, 16'hFF7C);
    expect_out("clamp_9959", 0, 16'h9959, 0, 0, 0);
    cyc(0, 0, 0, 1, 16'h0);
    cyc(0, 1, 0, 0, 16'h0);
    expect_out("start_at_zero", 0, 16'h0000, 0, 0, 0);

    // Asynchronous reset mid-run at 42:17
    cyc(1, 0, 0, 0, 16'h4217);
    cyc(0, 1, 0, 0, 16'h0);
    expect_out("run_4217", 0, 16'h4217, 1, 0, 0);
    @(posedge clk); #2;
    reset_p = 1'b1;
    #1;
    expect_out("async_reset", 0, 16'h0000, 0, 0, 0);
    @(posedge clk); #1;
    reset_p = 1'b0;

    // clear beats load in the same cycle
    cyc(1, 0, 0, 0, 16'h4217);
    expect_out("reload_4217", 0, 16'h4217, 0, 0, 0);
    cyc(1, 0, 0, 1, 16'h1234);
    expect_out("clear_over_load", 0, 16'h0000, 0, 0, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
